// File: rtl/pcfx_scsi_pkg.sv
// ============================================================================
// Module      : pcfx_scsi_pkg
// Description : Shared types, constants and helpers for the SCSI CD target.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pcfx_scsi_pkg;

    // Bus phase of the target state machine
    typedef enum logic [2:0] {
        PH_BUS_FREE = 3'd0,
        PH_SELECTED = 3'd1,
        PH_COMMAND  = 3'd2,
        PH_DATA_IN  = 3'd3,
        PH_STATUS   = 3'd4,
        PH_MSG_IN   = 3'd5
    } scsi_phase_t;

    // Message byte sent in MESSAGE IN at the end of every command
    localparam logic [7:0] SCSI_MSG_CMD_COMPLETE = 8'h00;

    // Phase lines as {MSG, CD, IO}, 1 = asserted (bus level is the inverse)
    localparam logic [2:0] c_lines_idle    = 3'b000;
    localparam logic [2:0] c_lines_command = 3'b010;
    localparam logic [2:0] c_lines_data_in = 3'b001;
    localparam logic [2:0] c_lines_status  = 3'b011;
    localparam logic [2:0] c_lines_msg_in  = 3'b111;

    // CDB length from the group code in bits [7:5] of the opcode
    function automatic logic [3:0] cdb_length(input logic [7:0] opcode);
        case (opcode[7:5])
            3'd0:       return 4'd6;
            3'd1, 3'd2: return 4'd10;
            3'd5:       return 4'd12;
            default:    return 4'd6;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/scsi_target_handshake.sv
// ============================================================================
// Module      : scsi_target_handshake
// Description : Target-side REQ/ACK engine with bus settle counter. A start
//               pulse runs one byte: settle, assert REQ, wait ACK, release
//               REQ, wait ACK release, then done.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module scsi_target_handshake #(
    parameter int unsigned BUS_SETTLE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_ce,
    input  logic i_bus_rst,
    input  logic i_start,
    input  logic i_ack_n,
    output logic o_req_n,
    output logic o_latch,
    output logic o_done
);

    typedef enum logic [1:0] {
        HS_IDLE     = 2'd0,
        HS_SETTLE   = 2'd1,
        HS_WAIT_ACK = 2'd2,
        HS_WAIT_REL = 2'd3
    } hs_state_t;

    localparam logic [7:0] c_settle = 8'(BUS_SETTLE);

    hs_state_t  r_state;
    logic [7:0] r_settle;
    logic       r_req_n;

    // Latch/done are combinational so the owner acts in the very cycle ACK
    // is first seen low (data still valid) or first seen released.
    assign o_latch = i_ce && (r_state == HS_WAIT_ACK) && !i_ack_n;
    assign o_done  = i_ce && (r_state == HS_WAIT_REL) && i_ack_n;
    assign o_req_n = r_req_n;

    // Settle countdown and REQ sequencing; REQ only rises again with ACK high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= HS_IDLE;
            r_settle <= 8'd0;
            r_req_n  <= 1'b1;
        end else if (i_bus_rst) begin
            r_state  <= HS_IDLE;
            r_settle <= 8'd0;
            r_req_n  <= 1'b1;
        end else if (i_ce) begin
            case (r_state)
                HS_IDLE: begin
                    if (i_start) begin
                        r_settle <= c_settle;
                        r_state  <= HS_SETTLE;
                    end
                end
                HS_SETTLE: begin
                    if (r_settle != 8'd0) begin
                        r_settle <= r_settle - 8'd1;
                    end else if (i_ack_n) begin
                        r_req_n <= 1'b0;
                        r_state <= HS_WAIT_ACK;
                    end
                end
                HS_WAIT_ACK: begin
                    if (!i_ack_n) begin
                        r_req_n <= 1'b1;
                        r_state <= HS_WAIT_REL;
                    end
                end
                HS_WAIT_REL: begin
                    if (i_ack_n) begin
                        r_state <= HS_IDLE;
                    end
                end
                default: r_state <= HS_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/scsi_cd_target.sv
// ============================================================================
// Module      : scsi_cd_target
// Description : SCSI CD-ROM target: selection, COMMAND, DATA IN, STATUS and
//               MESSAGE IN phase sequencing with a command/read backend.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module scsi_cd_target #(
    parameter int unsigned TARGET_ID  = 0,
    parameter int unsigned BUS_SETTLE = 4
) (
    input  logic       CLK,
    input  logic       RES,
    input  logic       CE,
    input  logic [7:0] SCSI_DI,
    input  logic       SCSI_DOE_I,
    input  logic       SCSI_ATNn,
    input  logic       SCSI_ACKn,
    input  logic       SCSI_RSTn,
    input  logic       SCSI_SELn,
    output logic [7:0] SCSI_DO,
    output logic       SCSI_BSYn,
    output logic       SCSI_REQn,
    output logic       SCSI_MSGn,
    output logic       SCSI_CDn,
    output logic       SCSI_IOn,
    output logic [7:0] CMD_BYTE,
    output logic       CMD_STB,
    output logic       CMD_DONE,
    input  logic [7:0] DIN_DATA,
    input  logic       DIN_VALID,
    input  logic       DIN_LAST,
    output logic       DIN_READY,
    input  logic [7:0] STAT_BYTE,
    input  logic       STAT_VALID
);

    import pcfx_scsi_pkg::*;

    scsi_phase_t r_state;
    logic        r_bsy_n;
    logic [2:0]  r_lines_n;     // {MSG, CD, IO} at bus level
    logic [7:0]  r_do;
    logic [7:0]  r_cmd_byte;
    logic        r_cmd_stb;
    logic        r_cmd_done;
    logic        r_din_ready;
    logic        r_hs_start;
    logic        r_xfer;        // a byte is loaded and its handshake is running
    logic        r_last;
    logic        r_cmd_idle;    // all CDB bytes taken, waiting for the backend
    logic [3:0]  r_cmd_cnt;
    logic [3:0]  r_cmd_len;
    logic        w_hs_latch;
    logic        w_hs_done;
    logic        w_req_n;
    logic        w_unused_atn;

    assign w_unused_atn = SCSI_ATNn;

    scsi_target_handshake #(
        .BUS_SETTLE (BUS_SETTLE)
    ) u_handshake (
        .clk       (CLK),
        .rst       (RES),
        .i_ce      (CE),
        .i_bus_rst (!SCSI_RSTn),
        .i_start   (r_hs_start),
        .i_ack_n   (SCSI_ACKn),
        .o_req_n   (w_req_n),
        .o_latch   (w_hs_latch),
        .o_done    (w_hs_done)
    );

    assign SCSI_DO   = r_do;
    assign SCSI_BSYn = r_bsy_n;
    assign SCSI_REQn = w_req_n;
    assign SCSI_MSGn = r_lines_n[2];
    assign SCSI_CDn  = r_lines_n[1];
    assign SCSI_IOn  = r_lines_n[0];
    assign CMD_BYTE  = r_cmd_byte;
    assign CMD_STB   = r_cmd_stb;
    assign CMD_DONE  = r_cmd_done;
    assign DIN_READY = r_din_ready;

    // Phase sequencer; every load of SCSI_DO or phase entry kicks a handshake
    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            r_state     <= PH_BUS_FREE;
            r_bsy_n     <= 1'b1;
            r_lines_n   <= ~c_lines_idle;
            r_do        <= 8'h00;
            r_cmd_byte  <= 8'h00;
            r_cmd_stb   <= 1'b0;
            r_cmd_done  <= 1'b0;
            r_din_ready <= 1'b0;
            r_hs_start  <= 1'b0;
            r_xfer      <= 1'b0;
            r_last      <= 1'b0;
            r_cmd_idle  <= 1'b0;
            r_cmd_cnt   <= 4'd0;
            r_cmd_len   <= 4'd0;
        end else if (!SCSI_RSTn) begin
            r_state     <= PH_BUS_FREE;
            r_bsy_n     <= 1'b1;
            r_lines_n   <= ~c_lines_idle;
            r_do        <= 8'h00;
            r_cmd_byte  <= 8'h00;
            r_cmd_stb   <= 1'b0;
            r_cmd_done  <= 1'b0;
            r_din_ready <= 1'b0;
            r_hs_start  <= 1'b0;
            r_xfer      <= 1'b0;
            r_last      <= 1'b0;
            r_cmd_idle  <= 1'b0;
            r_cmd_cnt   <= 4'd0;
            r_cmd_len   <= 4'd0;
        end else if (CE) begin
            r_cmd_stb   <= 1'b0;
            r_cmd_done  <= 1'b0;
            r_din_ready <= 1'b0;
            r_hs_start  <= 1'b0;
            case (r_state)
                PH_BUS_FREE: begin
                    if (!SCSI_SELn && SCSI_DOE_I && SCSI_DI[TARGET_ID] && r_bsy_n) begin
                        r_bsy_n <= 1'b0;
                        r_state <= PH_SELECTED;
                    end
                end
                PH_SELECTED: begin
                    if (SCSI_SELn) begin
                        r_state    <= PH_COMMAND;
                        r_lines_n  <= ~c_lines_command;
                        r_cmd_cnt  <= 4'd0;
                        r_cmd_len  <= 4'd6;   // replaced once byte 0 arrives
                        r_cmd_idle <= 1'b0;
                        r_hs_start <= 1'b1;
                    end
                end
                PH_COMMAND: begin
                    if (!r_cmd_idle) begin
                        if (w_hs_latch) begin
                            r_cmd_byte <= SCSI_DI;
                            r_cmd_stb  <= 1'b1;
                            if (r_cmd_cnt == 4'd0) begin
                                r_cmd_len <= cdb_length(SCSI_DI);
                            end
                            if (r_cmd_cnt != 4'hF) begin
                                r_cmd_cnt <= r_cmd_cnt + 4'd1;
                            end
                        end
                        if (w_hs_done) begin
                            if (r_cmd_cnt >= r_cmd_len) begin
                                r_cmd_done <= 1'b1;
                                r_cmd_idle <= 1'b1;
                            end else begin
                                r_hs_start <= 1'b1;
                            end
                        end
                    end else if (DIN_VALID) begin
                        r_state   <= PH_DATA_IN;
                        r_lines_n <= ~c_lines_data_in;
                        r_xfer    <= 1'b0;
                    end else if (STAT_VALID) begin
                        r_state   <= PH_STATUS;
                        r_lines_n <= ~c_lines_status;
                        r_xfer    <= 1'b0;
                    end
                end
                PH_DATA_IN: begin
                    if (!r_xfer) begin
                        if (DIN_VALID) begin
                            r_do        <= DIN_DATA;
                            r_din_ready <= 1'b1;
                            r_last      <= DIN_LAST;
                            r_xfer      <= 1'b1;
                            r_hs_start  <= 1'b1;
                        end
                    end else if (w_hs_done) begin
                        r_xfer <= 1'b0;
                        if (r_last) begin
                            r_state   <= PH_STATUS;
                            r_lines_n <= ~c_lines_status;
                        end
                    end
                end
                PH_STATUS: begin
                    if (!r_xfer) begin
                        if (STAT_VALID) begin
                            r_do       <= STAT_BYTE;
                            r_xfer     <= 1'b1;
                            r_hs_start <= 1'b1;
                        end
                    end else if (w_hs_done) begin
                        r_state    <= PH_MSG_IN;
                        r_lines_n  <= ~c_lines_msg_in;
                        r_do       <= SCSI_MSG_CMD_COMPLETE;
                        r_hs_start <= 1'b1;
                    end
                end
                PH_MSG_IN: begin
                    if (w_hs_done) begin
                        r_state   <= PH_BUS_FREE;
                        r_bsy_n   <= 1'b1;
                        r_lines_n <= ~c_lines_idle;
                        r_do      <= 8'h00;
                        r_xfer    <= 1'b0;
                    end
                end
                default: r_state <= PH_BUS_FREE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_scsi_cd_target.sv
// ============================================================================
// Module      : tb_scsi_cd_target
// Description : Initiator/backend model driving scsi_cd_target through full
//               transactions, bus resets and selection corner cases.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_scsi_cd_target;

    localparam int unsigned TARGET_ID  = 0;
    localparam int unsigned BUS_SETTLE = 4;

    logic       CLK = 1'b0;
    logic       RES = 1'b1;
    logic       CE = 1'b1;
    logic [7:0] SCSI_DI = 8'h00;
    logic       SCSI_DOE_I = 1'b0;
    logic       SCSI_ATNn = 1'b1;
    logic       SCSI_ACKn = 1'b1;
    logic       SCSI_RSTn = 1'b1;
    logic       SCSI_SELn = 1'b1;
    logic [7:0] SCSI_DO;
    logic       SCSI_BSYn, SCSI_REQn, SCSI_MSGn, SCSI_CDn, SCSI_IOn;
    logic [7:0] CMD_BYTE;
    logic       CMD_STB, CMD_DONE;
    logic [7:0] DIN_DATA = 8'h00;
    logic       DIN_VALID = 1'b0;
    logic       DIN_LAST = 1'b0;
    logic       DIN_READY;
    logic [7:0] STAT_BYTE = 8'h00;
    logic       STAT_VALID = 1'b0;

    scsi_cd_target #(
        .TARGET_ID  (TARGET_ID),
        .BUS_SETTLE (BUS_SETTLE)
    ) dut (
        .CLK        (CLK),
        .RES        (RES),
        .CE         (CE),
        .SCSI_DI    (SCSI_DI),
        .SCSI_DOE_I (SCSI_DOE_I),
        .SCSI_ATNn  (SCSI_ATNn),
        .SCSI_ACKn  (SCSI_ACKn),
        .SCSI_RSTn  (SCSI_RSTn),
        .SCSI_SELn  (SCSI_SELn),
        .SCSI_DO    (SCSI_DO),
        .SCSI_BSYn  (SCSI_BSYn),
        .SCSI_REQn  (SCSI_REQn),
        .SCSI_MSGn  (SCSI_MSGn),
        .SCSI_CDn   (SCSI_CDn),
        .SCSI_IOn   (SCSI_IOn),
        .CMD_BYTE   (CMD_BYTE),
        .CMD_STB    (CMD_STB),
        .CMD_DONE   (CMD_DONE),
        .DIN_DATA   (DIN_DATA),
        .DIN_VALID  (DIN_VALID),
        .DIN_LAST   (DIN_LAST),
        .DIN_READY  (DIN_READY),
        .STAT_BYTE  (STAT_BYTE),
        .STAT_VALID (STAT_VALID)
    );

    always #5 CLK = ~CLK;

    // Bus-level phase expectations as {MSGn, CDn, IOn}
    localparam logic [2:0] c_ph_cmd  = 3'b101;
    localparam logic [2:0] c_ph_data = 3'b110;
    localparam logic [2:0] c_ph_stat = 3'b100;
    localparam logic [2:0] c_ph_msg  = 3'b000;

    int errors = 0;
    int checks = 0;

    logic [7:0] cmd_q[$];
    int done_cnt = 0;
    int rdy_cnt  = 0;

    logic [7:0] tx_cmd[$];
    logic [7:0] tx_data[$];
    logic [7:0] tx_stat;

    // Passive observer of backend-side strobes
    always @(negedge CLK) begin
        if (CMD_STB)   cmd_q.push_back(CMD_BYTE);
        if (CMD_DONE)  done_cnt++;
        if (DIN_READY) rdy_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // CDB length from the group code table
    function automatic int exp_cdb_len(input logic [7:0] op);
        int g;
        g = int'(op) / 32;
        if (g == 1 || g == 2) return 10;
        if (g == 5) return 12;
        return 6;
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic wait_req(input logic lvl, input string tag);
        int n = 0;
        while (SCSI_REQn !== lvl && n < 500) begin
            @(negedge CLK);
            n++;
        end
        if (SCSI_REQn !== lvl) chk({tag, " timeout"}, 32'(SCSI_REQn), 32'(lvl));
    endtask

    task automatic select_target(input logic [7:0] ids);
        int n = 0;
        SCSI_DI = ids; SCSI_DOE_I = 1'b1; SCSI_SELn = 1'b0;
        while (SCSI_BSYn !== 1'b0 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        chk("select bsy", 32'(SCSI_BSYn), 32'd0);
        SCSI_SELn = 1'b1; SCSI_DOE_I = 1'b0; SCSI_DI = 8'h00;
    endtask

    task automatic send_cmd(input logic [7:0] b);
        wait_req(1'b0, "cmd req");
        chk("cmd phase", 32'({SCSI_MSGn, SCSI_CDn, SCSI_IOn}), 32'(c_ph_cmd));
        SCSI_DI = b; SCSI_DOE_I = 1'b1; SCSI_ACKn = 1'b0;
        wait_req(1'b1, "cmd req release");
        SCSI_ACKn = 1'b1; SCSI_DOE_I = 1'b0; SCSI_DI = 8'h00;
        @(negedge CLK);
    endtask

    task automatic recv(input logic [2:0] ph, input logic [7:0] exp, input string tag, input int hold);
        logic ok;
        wait_req(1'b0, tag);
        chk({tag, " phase"}, 32'({SCSI_MSGn, SCSI_CDn, SCSI_IOn}), 32'(ph));
        chk({tag, " byte"}, 32'(SCSI_DO), 32'(exp));
        SCSI_ACKn = 1'b0;
        @(negedge CLK);
        chk({tag, " req release"}, 32'(SCSI_REQn), 32'd1);
        if (hold > 0) begin
            ok = 1'b1;
            repeat (hold) begin
                @(negedge CLK);
                if (SCSI_REQn !== 1'b1) ok = 1'b0;
            end
            chk({tag, " req held while ack"}, 32'(ok), 32'd1);
        end
        SCSI_ACKn = 1'b1;
        @(negedge CLK);
    endtask

    task automatic supply(input logic [7:0] d, input logic last, input int stall);
        int n = 0;
        int k = 0;
        int r0;
        logic ok;
        if (stall > 0) begin
            r0 = rdy_cnt;
            ok = 1'b1;
            repeat (stall) begin
                @(negedge CLK);
                if (SCSI_REQn !== 1'b1) ok = 1'b0;
            end
            chk("stall req negated", 32'(ok), 32'd1);
            chk("stall no din_ready", 32'(rdy_cnt), 32'(r0));
        end
        DIN_DATA = d; DIN_VALID = 1'b1; DIN_LAST = last;
        while (DIN_READY !== 1'b1 && n < 50) begin
            @(negedge CLK);
            n++;
        end
        chk("din_ready pulse", 32'(DIN_READY), 32'd1);
        DIN_VALID = 1'b0; DIN_LAST = 1'b0;
        while (SCSI_REQn !== 1'b0 && k < 50) begin
            @(negedge CLK);
            k++;
        end
        chk("settle before req", 32'(k > int'(BUS_SETTLE) && k < 50), 32'd1);
    endtask

    // Full transaction built from tx_cmd / tx_data / tx_stat
    task automatic run_tx(input int stall_idx, input int hold_idx, input logic both_valid);
        int d0, r0;
        cmd_q.delete();
        d0 = done_cnt;
        r0 = rdy_cnt;
        select_target(8'h80 | (8'h01 << TARGET_ID));
        foreach (tx_cmd[i]) send_cmd(tx_cmd[i]);
        step(2);
        chk("cmd strobe count", 32'(cmd_q.size()), 32'(tx_cmd.size()));
        foreach (tx_cmd[i]) begin
            if (i < cmd_q.size()) chk("cmd byte", 32'(cmd_q[i]), 32'(tx_cmd[i]));
        end
        chk("cmd done count", 32'(done_cnt - d0), 32'd1);
        chk("cmd idle req", 32'(SCSI_REQn), 32'd1);
        if (both_valid) begin
            STAT_BYTE = tx_stat; STAT_VALID = 1'b1;
        end
        foreach (tx_data[i]) begin
            supply(tx_data[i], i == tx_data.size() - 1, (i == stall_idx) ? 50 : 0);
            recv(c_ph_data, tx_data[i], "data", (i == hold_idx) ? 20 : 0);
        end
        STAT_BYTE = tx_stat; STAT_VALID = 1'b1;
        recv(c_ph_stat, tx_stat, "status", 0);
        STAT_VALID = 1'b0;
        recv(c_ph_msg, 8'h00, "message", 0);
        chk("release lines", 32'({SCSI_BSYn, SCSI_REQn, SCSI_MSGn, SCSI_CDn, SCSI_IOn}), 32'h1f);
        chk("release data", 32'(SCSI_DO), 32'h00);
        chk("din_ready count", 32'(rdy_cnt - r0), 32'(tx_data.size()));
    endtask

    task automatic build_cmd(input logic [7:0] op);
        tx_cmd.delete();
        tx_cmd.push_back(op);
        for (int i = 1; i < exp_cdb_len(op); i++) tx_cmd.push_back(8'($urandom));
    endtask

    task automatic check_released(input string tag);
        chk({tag, " lines"}, 32'({SCSI_BSYn, SCSI_REQn, SCSI_MSGn, SCSI_CDn, SCSI_IOn}), 32'h1f);
        chk({tag, " data"}, 32'(SCSI_DO), 32'h00);
        chk({tag, " strobes"}, 32'({CMD_STB, CMD_DONE, DIN_READY}), 32'd0);
    endtask

    initial begin
        logic [2:0] grp_tab[6];
        grp_tab = '{3'd0, 3'd1, 3'd2, 3'd5, 3'd3, 3'd7};

        // Reset state
        step(3);
        check_released("reset");
        RES = 1'b0;
        step(2);

        // Selection with another target's ID bit only
        SCSI_DI = 8'h02; SCSI_DOE_I = 1'b1; SCSI_SELn = 1'b0;
        step(10);
        chk("mismatch bsy", 32'(SCSI_BSYn), 32'd1);
        chk("mismatch req", 32'(SCSI_REQn), 32'd1);
        SCSI_SELn = 1'b1; SCSI_DOE_I = 1'b0; SCSI_DI = 8'h00;
        step(2);

        // TEST UNIT READY
        tx_cmd = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        tx_data.delete();
        tx_stat = 8'h00;
        run_tx(-1, -1, 1'b0);
        step(3);

        // READ(10) with a backend stall and a long ACK
        build_cmd(8'h28);
        tx_data = '{8'hAA, 8'h55, 8'hC3};
        tx_stat = 8'h00;
        run_tx(1, 2, 1'b0);
        step(3);

        // Randomized commands, data and status
        for (int t = 0; t < 4; t++) begin
            build_cmd({grp_tab[$urandom_range(0, 5)], 5'($urandom)});
            tx_data.delete();
            for (int i = 0; i < int'($urandom_range(1, 5)); i++) tx_data.push_back(8'($urandom));
            tx_stat = 8'($urandom);
            run_tx(-1, -1, (t % 2) == 1);
            step(2);
        end

        // Bus reset while REQ is asserted in DATA IN
        build_cmd(8'h28);
        select_target(8'h01);
        foreach (tx_cmd[i]) send_cmd(tx_cmd[i]);
        step(2);
        DIN_DATA = 8'h5A; DIN_VALID = 1'b1; DIN_LAST = 1'b0;
        step(2);
        DIN_VALID = 1'b0;
        wait_req(1'b0, "pre bus reset req");
        chk("pre bus reset req", 32'(SCSI_REQn), 32'd0);
        SCSI_RSTn = 1'b0;
        @(negedge CLK);
        check_released("bus reset");
        SCSI_RSTn = 1'b1;
        step(3);
        chk("bus reset stays free", 32'(SCSI_BSYn), 32'd1);
        tx_cmd = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        tx_data = '{8'h11};
        tx_stat = 8'h02;
        run_tx(-1, -1, 1'b0);
        step(2);

        // Asynchronous RES in COMMAND with REQ asserted
        select_target(8'h01);
        send_cmd(8'h12);
        send_cmd(8'h34);
        wait_req(1'b0, "pre RES req");
        chk("pre RES req", 32'(SCSI_REQn), 32'd0);
        #2 RES = 1'b1;
        #1 check_released("async RES");
        @(negedge CLK);
        RES = 1'b0;
        step(2);
        build_cmd(8'hA8);
        tx_data = '{8'h01, 8'h02};
        tx_stat = 8'h00;
        run_tx(-1, 0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute bound on run time
    initial begin
        #400000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
